// File: rtl/time_entry_ctrl.sv
// time_entry_ctrl: keypad time-entry sequencer for the clock setting path.
// Collects two BCD digits per field (hour, minute, second). Each field is
// range-checked on '#'. The committed binary time is then presented with a
// one-cycle load strobe. A session is abandoned after key inactivity.
module time_entry_ctrl #(
   parameter int TIMEOUT_CYCLES = 10_000_000,
   parameter int TMR_W          = 24
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic       busy,
   output logic       hour_en,
   output logic       min_en,
   output logic       sec_en,
   output logic [1:0] digit_cnt,
   output logic [4:0] hour_out,
   output logic [5:0] min_out,
   output logic [5:0] sec_out,
   output logic       load,
   output logic       error,
   output logic       abort
);

   typedef enum logic [2:0] {IDLE, HOUR, MIN, SEC, DONE} state_t;

   localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]       KEY_CLEAR  = 4'd10;
   localparam logic [3:0]       KEY_ENTER  = 4'd11;

   state_t             state_q, state_d;
   logic [3:0]         tens_q, tens_d, ones_q, ones_d;
   logic [1:0]         cnt_q, cnt_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [4:0]         hour_stg_q, hour_stg_d;
   logic [5:0]         min_stg_q, min_stg_d;
   logic [4:0]         hour_out_d;
   logic [5:0]         min_out_d, sec_out_d;
   logic               load_d, error_d, abort_d;
   logic [6:0]         field_val, field_lim;

   // Two typed digits combine into the field value. Seven bits are wide
   // enough for 99, so the range check sees the true value before the
   // result is truncated to the field width.
   assign field_val = 7'(tens_q) * 7'd10 + 7'(ones_q);
   assign field_lim = (state_q == HOUR) ? 7'd23 : 7'd59;
   assign digit_cnt = cnt_q;

   // Next-state logic: decode keys, run the inactivity timer and commit fields.
   always_comb begin
      state_d    = state_q;
      tens_d     = tens_q;
      ones_d     = ones_q;
      cnt_d      = cnt_q;
      timer_d    = timer_q;
      hour_stg_d = hour_stg_q;
      min_stg_d  = min_stg_q;
      hour_out_d = hour_out;
      min_out_d  = min_out;
      sec_out_d  = sec_out;
      load_d     = 1'b0;
      error_d    = 1'b0;
      abort_d    = 1'b0;
      case (state_q)
         IDLE: begin
            timer_d = '0;
            if (start) begin
               state_d = HOUR;
               tens_d  = '0;
               ones_d  = '0;
               cnt_d   = '0;
            end
         end
         HOUR, MIN, SEC: begin
            if (key_valid) begin
               timer_d = '0;
               if (key_code <= 4'd9) begin
                  if (cnt_q == 2'd0) begin
                     tens_d = key_code;
                     cnt_d  = 2'd1;
                  end else if (cnt_q == 2'd1) begin
                     ones_d = key_code;
                     cnt_d  = 2'd2;
                  end
               end else if (key_code == KEY_CLEAR) begin
                  tens_d = '0;
                  ones_d = '0;
                  cnt_d  = '0;
               end else if (key_code == KEY_ENTER) begin
                  tens_d = '0;
                  ones_d = '0;
                  cnt_d  = '0;
                  if (cnt_q == 2'd2 && field_val <= field_lim) begin
                     if (state_q == HOUR) begin
                        hour_stg_d = field_val[4:0];
                        state_d    = MIN;
                     end else if (state_q == MIN) begin
                        min_stg_d = field_val[5:0];
                        state_d   = SEC;
                     end else begin
                        hour_out_d = hour_stg_q;
                        min_out_d  = min_stg_q;
                        sec_out_d  = field_val[5:0];
                        load_d     = 1'b1;
                        state_d    = DONE;
                     end
                  end else begin
                     error_d = 1'b1;
                  end
               end
            end else if (timer_q == TIMER_LAST) begin
               abort_d = 1'b1;
               timer_d = '0;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, staging and output registers. The field enables come from the
   // next state, so they line up with the state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         tens_q     <= '0;
         ones_q     <= '0;
         cnt_q      <= '0;
         timer_q    <= '0;
         hour_stg_q <= '0;
         min_stg_q  <= '0;
         hour_out   <= '0;
         min_out    <= '0;
         sec_out    <= '0;
         load       <= 1'b0;
         error      <= 1'b0;
         abort      <= 1'b0;
         busy       <= 1'b0;
         hour_en    <= 1'b0;
         min_en     <= 1'b0;
         sec_en     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tens_q     <= tens_d;
         ones_q     <= ones_d;
         cnt_q      <= cnt_d;
         timer_q    <= timer_d;
         hour_stg_q <= hour_stg_d;
         min_stg_q  <= min_stg_d;
         hour_out   <= hour_out_d;
         min_out    <= min_out_d;
         sec_out    <= sec_out_d;
         load       <= load_d;
         error      <= error_d;
         abort      <= abort_d;
         busy       <= (state_d == HOUR) || (state_d == MIN) || (state_d == SEC);
         hour_en    <= (state_d == HOUR);
         min_en     <= (state_d == MIN);
         sec_en     <= (state_d == SEC);
      end
   end

endmodule

// File: tb/tb_time_entry_ctrl.sv
// tb_time_entry_ctrl: self-checking bench for time_entry_ctrl.
// It runs directed keypad scenarios and randomized sessions. The randomized
// sessions are checked against a digit-queue model of the entry rules.
module tb_time_entry_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'd0;
   logic       busy, hour_en, min_en, sec_en, load, error, abort;
   logic [1:0] digit_cnt;
   logic [4:0] hour_out;
   logic [5:0] min_out, sec_out;

   int checks = 0;
   int failures = 0;

   // Reference model: field index (0 idle, 1..3 edit, 4 done) and digits typed so far
   int m_field = 0;
   int m_dig[$];
   int m_stage[4];
   int m_out[4];

   time_entry_ctrl #(.TIMEOUT_CYCLES(16), .TMR_W(8)) dut (
      .clock(clock), .reset(reset), .start(start), .key_valid(key_valid),
      .key_code(key_code), .busy(busy), .hour_en(hour_en), .min_en(min_en),
      .sec_en(sec_en), .digit_cnt(digit_cnt), .hour_out(hour_out),
      .min_out(min_out), .sec_out(sec_out), .load(load), .error(error),
      .abort(abort)
   );

   // 10-time-unit clock
   always #5 clock = ~clock;

   task automatic send_key(input int c);
      @(negedge clock);
      key_valid = 1'b1;
      key_code  = 4'(c);
      @(negedge clock);
      key_valid = 1'b0;
      key_code  = 4'd0;
   endtask

   task automatic pulse_start();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic model_key(input int c, output bit e, output bit l);
      int lim, val;
      e = 1'b0;
      l = 1'b0;
      if (m_field >= 1 && m_field <= 3) begin
         if (c <= 9) begin
            if (m_dig.size() < 2) m_dig.push_back(c);
         end else if (c == 10) begin
            m_dig.delete();
         end else if (c == 11) begin
            lim = (m_field == 1) ? 23 : 59;
            val = (m_dig.size() == 2) ? m_dig[0] * 10 + m_dig[1] : 999;
            m_dig.delete();
            if (val <= lim) begin
               m_stage[m_field] = val;
               if (m_field == 3) begin
                  for (int i = 1; i < 4; i++) m_out[i] = m_stage[i];
                  l = 1'b1;
                  m_field = 4;
               end else begin
                  m_field = m_field + 1;
               end
            end else begin
               e = 1'b1;
            end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if ({busy, hour_en, min_en, sec_en, load, error, abort} !== 7'b0) begin
         failures++;
         $display("[TB] FAIL reset_flags got %b want 0000000", {busy, hour_en, min_en, sec_en, load, error, abort});
      end
      checks++;
      if ({digit_cnt, hour_out, min_out, sec_out} !== 19'd0) begin
         failures++;
         $display("[TB] FAIL reset_values got cnt=%0d h=%0d m=%0d s=%0d want zeros", digit_cnt, hour_out, min_out, sec_out);
      end
      reset = 1'b1;
   endtask

   task automatic test_basic_entry();
      int seq[9] = '{1, 2, 11, 3, 4, 11, 5, 6, 11};
      pulse_start();
      checks++;
      if (busy !== 1'b1 || hour_en !== 1'b1 || digit_cnt !== 2'd0) begin
         failures++;
         $display("[TB] FAIL start_hour got busy=%b hour_en=%b cnt=%0d want 1 1 0", busy, hour_en, digit_cnt);
      end
      for (int i = 0; i < 9; i++) begin
         send_key(seq[i]);
         if (i != 8) begin
            checks++;
            if (load !== 1'b0) begin
               failures++;
               $display("[TB] FAIL basic_early_load got %b want 0 at key %0d", load, i);
            end
         end
      end
      checks++;
      if (load !== 1'b1 || busy !== 1'b0 || hour_out !== 5'd12 || min_out !== 6'd34 || sec_out !== 6'd56) begin
         failures++;
         $display("[TB] FAIL basic_load got load=%b busy=%b %0d:%0d:%0d want 1 0 12:34:56", load, busy, hour_out, min_out, sec_out);
      end
      @(negedge clock);
      checks++;
      if (load !== 1'b0 || busy !== 1'b0 || hour_out !== 5'd12 || sec_out !== 6'd56) begin
         failures++;
         $display("[TB] FAIL basic_after got load=%b busy=%b h=%0d s=%0d want 0 0 12 56", load, busy, hour_out, sec_out);
      end
   endtask

   task automatic test_field_errors();
      pulse_start();
      send_key(2); send_key(5); send_key(11);
      checks++;
      if (error !== 1'b1 || hour_en !== 1'b1 || digit_cnt !== 2'd0) begin
         failures++;
         $display("[TB] FAIL hour_range got err=%b hour_en=%b cnt=%0d want 1 1 0", error, hour_en, digit_cnt);
      end
      @(negedge clock);
      checks++;
      if (error !== 1'b0) begin
         failures++;
         $display("[TB] FAIL error_width got %b want 0", error);
      end
      send_key(2); send_key(3); send_key(11);
      checks++;
      if (min_en !== 1'b1 || hour_en !== 1'b0 || error !== 1'b0) begin
         failures++;
         $display("[TB] FAIL hour_23 got min_en=%b hour_en=%b err=%b want 1 0 0", min_en, hour_en, error);
      end
      pulse_start();
      checks++;
      if (min_en !== 1'b1 || digit_cnt !== 2'd0) begin
         failures++;
         $display("[TB] FAIL start_busy got min_en=%b cnt=%0d want 1 0", min_en, digit_cnt);
      end
      send_key(7); send_key(11);
      checks++;
      if (error !== 1'b1 || min_en !== 1'b1 || digit_cnt !== 2'd0) begin
         failures++;
         $display("[TB] FAIL min_short got err=%b min_en=%b cnt=%0d want 1 1 0", error, min_en, digit_cnt);
      end
      send_key(5); send_key(9); send_key(9);
      checks++;
      if (digit_cnt !== 2'd2) begin
         failures++;
         $display("[TB] FAIL third_digit got cnt=%0d want 2", digit_cnt);
      end
      send_key(11);
      checks++;
      if (sec_en !== 1'b1 || error !== 1'b0) begin
         failures++;
         $display("[TB] FAIL min_59 got sec_en=%b err=%b want 1 0", sec_en, error);
      end
      send_key(4); send_key(10);
      checks++;
      if (digit_cnt !== 2'd0) begin
         failures++;
         $display("[TB] FAIL star_clear got cnt=%0d want 0", digit_cnt);
      end
      send_key(0); send_key(7); send_key(11);
      checks++;
      if (load !== 1'b1 || hour_out !== 5'd23 || min_out !== 6'd59 || sec_out !== 6'd7) begin
         failures++;
         $display("[TB] FAIL sec_07 got load=%b %0d:%0d:%0d want 1 23:59:7", load, hour_out, min_out, sec_out);
      end
      @(negedge clock);
   endtask

   task automatic test_timeout();
      int seen = -1;
      pulse_start();
      send_key(1);
      for (int i = 1; i <= 40 && seen < 0; i++) begin
         @(negedge clock);
         if (load === 1'b1) begin
            checks++;
            failures++;
            $display("[TB] FAIL timeout_load got 1 want 0 at cycle %0d", i);
         end
         if (abort === 1'b1) seen = i;
      end
      checks++;
      if (seen != 16) begin
         failures++;
         $display("[TB] FAIL abort_cycle got %0d want 16", seen);
      end
      checks++;
      if (busy !== 1'b0 || hour_out !== 5'd23 || min_out !== 6'd59 || sec_out !== 6'd7) begin
         failures++;
         $display("[TB] FAIL abort_retain got busy=%b %0d:%0d:%0d want 0 23:59:7", busy, hour_out, min_out, sec_out);
      end
      @(negedge clock);
      checks++;
      if (abort !== 1'b0) begin
         failures++;
         $display("[TB] FAIL abort_width got %b want 0", abort);
      end
   endtask

   task automatic test_reset_midsession();
      pulse_start();
      send_key(1); send_key(8); send_key(11); send_key(4);
      checks++;
      if (min_en !== 1'b1 || digit_cnt !== 2'd1) begin
         failures++;
         $display("[TB] FAIL pre_reset got min_en=%b cnt=%0d want 1 1", min_en, digit_cnt);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({busy, min_en, load, error, abort, digit_cnt, hour_out, min_out, sec_out} !== 24'd0) begin
         failures++;
         $display("[TB] FAIL async_reset got busy=%b min_en=%b cnt=%0d h=%0d m=%0d s=%0d want zeros", busy, min_en, digit_cnt, hour_out, min_out, sec_out);
      end
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || load !== 1'b0) begin
         failures++;
         $display("[TB] FAIL post_reset got busy=%b load=%b want 0 0", busy, load);
      end
   endtask

   task automatic test_random_sessions();
      int  c, r, gap;
      bit  exp_e, exp_l;
      for (int i = 1; i < 4; i++) begin
         m_out[i] = 0;
         m_stage[i] = 0;
      end
      for (int s = 0; s < 8; s++) begin
         pulse_start();
         m_field = 1;
         m_dig.delete();
         for (int k = 0; k < 200 && m_field != 4; k++) begin
            r = $urandom_range(0, 99);
            if (r < 55) c = $urandom_range(0, 9);
            else if (r < 85) c = 11;
            else if (r < 92) c = 10;
            else c = $urandom_range(12, 15);
            send_key(c);
            model_key(c, exp_e, exp_l);
            checks++;
            if (error !== exp_e || load !== exp_l || abort !== 1'b0) begin
               failures++;
               $display("[TB] FAIL rand_strobe key=%0d got err=%b load=%b abort=%b want %b %b 0", c, error, load, abort, exp_e, exp_l);
            end
            checks++;
            if ({busy, hour_en, min_en, sec_en} !== {m_field >= 1 && m_field <= 3, m_field == 1, m_field == 2, m_field == 3}) begin
               failures++;
               $display("[TB] FAIL rand_state key=%0d got %b want field %0d", c, {busy, hour_en, min_en, sec_en}, m_field);
            end
            checks++;
            if (int'(digit_cnt) != m_dig.size()) begin
               failures++;
               $display("[TB] FAIL rand_cnt key=%0d got %0d want %0d", c, digit_cnt, m_dig.size());
            end
            checks++;
            if (int'(hour_out) != m_out[1] || int'(min_out) != m_out[2] || int'(sec_out) != m_out[3]) begin
               failures++;
               $display("[TB] FAIL rand_time got %0d:%0d:%0d want %0d:%0d:%0d", hour_out, min_out, sec_out, m_out[1], m_out[2], m_out[3]);
            end
            gap = $urandom_range(0, 3);
            if (m_field != 4) repeat (gap) @(negedge clock);
         end
         if (m_field == 4) begin
            @(negedge clock);
            checks++;
            if (load !== 1'b0 || busy !== 1'b0) begin
               failures++;
               $display("[TB] FAIL rand_done got load=%b busy=%b want 0 0", load, busy);
            end
            m_field = 0;
         end else begin
            @(negedge clock);
            reset = 1'b0;
            @(negedge clock);
            reset = 1'b1;
            m_field = 0;
            for (int i = 1; i < 4; i++) m_out[i] = 0;
         end
      end
   endtask

   // Runs every scenario in order and prints the summary line
   initial begin
      $display("[TB] starting time_entry_ctrl bench");
      test_reset();
      test_basic_entry();
      test_field_errors();
      test_timeout();
      test_reset_midsession();
      test_random_sessions();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
